// File: rtl/bloke2b_driver.sv
// Host-side sequencer for the bloke2b hash core: forwards a host byte stream
// into the core's start/din/finish handshake and shifts the digest bytes into a register.
module bloke2b_driver #(
  parameter int DIGEST_BYTES = 64,
  parameter int CNT_W        = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      host_start,
  input  logic                      host_empty,
  input  logic [7:0]                msg_data,
  input  logic                      msg_valid,
  input  logic                      msg_last,
  output logic                      msg_ready,
  output logic                      core_start,
  output logic                      core_finish,
  output logic [7:0]                core_din,
  output logic                      core_din_valid,
  output logic                      core_din_end,
  input  logic                      core_din_ready,
  input  logic [7:0]                core_dout,
  input  logic                      core_dout_valid,
  input  logic                      core_dout_end,
  output logic [8*DIGEST_BYTES-1:0] digest,
  output logic [CNT_W-1:0]          digest_len,
  output logic                      digest_valid,
  output logic                      overflow,
  output logic                      busy,
  output logic [2:0]                state_dbg
);

  localparam int DW = 8 * DIGEST_BYTES;
  localparam logic [CNT_W-1:0] FULL_LEN = CNT_W'(DIGEST_BYTES);
  localparam logic [CNT_W-1:0] MAX_LEN  = '1;
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_WAIT_RDY = 3'd2,
    S_FEED     = 3'd3,
    S_FINISH   = 3'd4,
    S_COLLECT  = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  state_t state;
  logic   empty_q;
  logic   in_feed;
  logic   capture;

  // Handshake: a message byte moves into the core on a rising edge where
  // msg_valid & msg_ready; in FEED msg_ready is core_din_ready, elsewhere 0.
  assign in_feed = (state == S_FEED);

  // The core may start emitting digest bytes any time after it has been
  // started, so capture is open from WAIT_RDY through COLLECT.
  assign capture = core_dout_valid &&
                   ((state == S_WAIT_RDY) || (state == S_FEED) ||
                    (state == S_FINISH)   || (state == S_COLLECT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      empty_q    <= 1'b0;
      digest     <= '0;
      digest_len <= '0;
      overflow   <= 1'b0;
    end else begin
      if (capture) begin
        digest <= {digest[DW-9:0], core_dout};
        if (digest_len != MAX_LEN) digest_len <= digest_len + ONE;
        if (digest_len >= FULL_LEN) overflow <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (host_start) begin
            empty_q    <= host_empty;
            digest     <= '0;
            digest_len <= '0;
            overflow   <= 1'b0;
            state      <= S_START;
          end
        end
        S_START:    state <= S_WAIT_RDY;
        S_WAIT_RDY: if (core_din_ready) state <= empty_q ? S_FINISH : S_FEED;
        S_FEED:     if (msg_valid && core_din_ready && msg_last) state <= S_FINISH;
        S_FINISH:   state <= S_COLLECT;
        // A byte arriving with end has already been shifted in above.
        S_COLLECT:  if (core_dout_end) state <= S_DONE;
        S_DONE:     state <= S_IDLE;
        default:    state <= S_IDLE;
      endcase
    end
  end

  assign core_start     = (state == S_START);
  assign core_finish    = (state == S_FINISH);
  assign digest_valid   = (state == S_DONE);
  assign busy           = (state != S_IDLE);
  assign msg_ready      = in_feed & core_din_ready;
  assign core_din_valid = in_feed & msg_valid;
  assign core_din       = in_feed ? msg_data : 8'h00;
  assign core_din_end   = 1'b0;
  assign state_dbg      = state;

endmodule

// File: tb/tb_bloke2b_driver.sv
// Randomized scoreboard bench for bloke2b_driver: a behavioural core model
// answers the handshake, monitors compare DUT traffic against expected queues.
module tb_bloke2b_driver;

  localparam int DB = 64;
  localparam int CW = 8;
  localparam int DW = 8 * DB;

  logic          clk = 1'b0;
  logic          rst;
  logic          host_start, host_empty;
  logic [7:0]    msg_data;
  logic          msg_valid, msg_last, msg_ready;
  logic          core_start, core_finish;
  logic [7:0]    core_din;
  logic          core_din_valid, core_din_end, core_din_ready;
  logic [7:0]    core_dout;
  logic          core_dout_valid, core_dout_end;
  logic [DW-1:0] digest;
  logic [CW-1:0] digest_len;
  logic          digest_valid, overflow, busy;
  logic [2:0]    state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // scoreboard queues
  logic [7:0]    exp_din_q[$];
  logic [DW-1:0] exp_dig_q[$];
  logic [CW-1:0] exp_len_q[$];
  logic          exp_ovf_q[$];

  logic [7:0]    msg_q[$];
  logic [7:0]    dout_q[$];
  logic          ready_pat[$];

  int exp_start_cyc = -1;
  int exp_fin_cyc   = -1;
  int exp_dv_cyc    = -1;
  int start_cnt     = 0;
  int exp_starts    = 0;
  int fin_cnt       = 0;
  int txn_xfers     = 0;
  int txn_din_valid = 0;
  bit finish_seen   = 1'b0;
  bit emitting      = 1'b0;
  bit ready_rand    = 1'b0;
  bit prev_dv       = 1'b0;
  bit have_prev     = 1'b0;
  logic [DW-1:0] prev_digest = '0;

  bloke2b_driver #(.DIGEST_BYTES(DB), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .host_start(host_start), .host_empty(host_empty),
    .msg_data(msg_data), .msg_valid(msg_valid), .msg_last(msg_last),
    .msg_ready(msg_ready),
    .core_start(core_start), .core_finish(core_finish),
    .core_din(core_din), .core_din_valid(core_din_valid),
    .core_din_end(core_din_end), .core_din_ready(core_din_ready),
    .core_dout(core_dout), .core_dout_valid(core_dout_valid),
    .core_dout_end(core_dout_end),
    .digest(digest), .digest_len(digest_len), .digest_valid(digest_valid),
    .overflow(overflow), .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------- check helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_dig(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired at cycle %0d, expected event never came", name, cyc);
  endtask

  task automatic chk_zero(input string name);
    chk(name, 64'({core_din, digest_len, msg_ready, core_start, core_finish,
                   core_din_valid, core_din_end, digest_valid, overflow, busy, |digest}),
        64'(0));
  endtask

  // ---------------- behavioural core model ----------------
  always begin
    @(posedge clk);
    #2;
    if (rst) begin
      emitting        = 1'b0;
      finish_seen     = 1'b0;
      core_dout_valid = 1'b0;
      core_dout_end   = 1'b0;
      core_din_ready  = 1'b0;
    end else begin
      if (ready_pat.size() > 0) core_din_ready = ready_pat.pop_front();
      else core_din_ready = ready_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
      core_dout_valid = 1'b0;
      core_dout_end   = 1'b0;
      if (emitting) begin
        if (dout_q.size() == 0) begin
          core_dout_end = 1'b1;
          emitting      = 1'b0;
        end else if ($urandom_range(0, 3) != 0) begin
          core_dout       = dout_q.pop_front();
          core_dout_valid = 1'b1;
          if (dout_q.size() == 0) begin
            core_dout_end = 1'b1;
            emitting      = 1'b0;
          end
        end
      end
      if (finish_seen) begin
        emitting    = 1'b1;
        finish_seen = 1'b0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst) begin
      prev_dv = 1'b0;
    end else begin
      if (prev_dv) chk("busy_after_done", 64'(busy), 64'(0));
      prev_dv = digest_valid;
      if (core_din_valid) txn_din_valid++;
      if (msg_ready) begin
        chk("ready_mirror", 64'(core_din_ready), 64'(1));
        chk("din_passthru", 64'({core_din_valid, core_din}), 64'({msg_valid, msg_data}));
      end
      if (core_din_valid && core_din_ready) begin
        txn_xfers++;
        if (exp_din_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL din_unexpected: got byte %0h, expected no transfer", core_din);
        end else begin
          chk("din_byte", 64'(core_din), 64'(exp_din_q.pop_front()));
        end
        if (msg_last) exp_fin_cyc = cyc + 1;
      end
      if (core_start) begin
        start_cnt++;
        chk("start_cycle", 64'(cyc), 64'(exp_start_cyc));
        exp_start_cyc = -1;
      end
      if (core_finish) begin
        fin_cnt++;
        finish_seen = 1'b1;
        chk("finish_no_din", 64'(core_din_valid), 64'(0));
        if (exp_fin_cyc >= 0) begin
          chk("finish_cycle", 64'(cyc), 64'(exp_fin_cyc));
          exp_fin_cyc = -1;
        end
      end
      if (core_dout_end) exp_dv_cyc = cyc + 1;
      if (digest_valid) begin
        chk("dv_cycle", 64'(cyc), 64'(exp_dv_cyc));
        exp_dv_cyc = -1;
        if (exp_dig_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL dv_unexpected: got digest_valid, expected none");
        end else begin
          chk_dig("digest", digest, exp_dig_q.pop_front());
          chk("digest_len", 64'(digest_len), 64'(exp_len_q.pop_front()));
          chk("overflow", 64'(overflow), 64'(exp_ovf_q.pop_front()));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_msg3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    msg_q.delete();
    msg_q.push_back(a);
    msg_q.push_back(b);
    msg_q.push_back(c);
  endtask

  task automatic set_msg_rand(input int n);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom));
  endtask

  task automatic run_hash(input bit empty, input int n_out, input bit ramp,
                          input bit use_bp, input bit gaps, input bit poke);
    logic [7:0]    outs[$];
    logic [DW-1:0] d;
    int            g;
    int            fin0;
    if (have_prev) chk_dig("digest_hold", digest, prev_digest);
    dout_q.delete();
    for (int i = 0; i < n_out; i++) begin
      outs.push_back(ramp ? 8'(i) : 8'($urandom));
      dout_q.push_back(outs[i]);
    end
    // reference: newest byte at the bottom, only the last DB bytes survive
    d = '0;
    for (int i = 0; i < DB; i++)
      if (n_out - 1 - i >= 0) d[8*i +: 8] = outs[n_out - 1 - i];
    exp_dig_q.push_back(d);
    exp_len_q.push_back((n_out > 255) ? 8'hFF : 8'(n_out));
    exp_ovf_q.push_back(n_out > DB);
    if (!empty) foreach (msg_q[i]) exp_din_q.push_back(msg_q[i]);
    txn_xfers     = 0;
    txn_din_valid = 0;
    fin0          = fin_cnt;

    @(posedge clk);
    #1;
    host_start    = 1'b1;
    host_empty    = empty;
    exp_start_cyc = cyc + 1;
    exp_starts++;
    if (use_bp) begin
      ready_pat.push_back(1'b1); ready_pat.push_back(1'b1); ready_pat.push_back(1'b1);
      ready_pat.push_back(1'b1); ready_pat.push_back(1'b0); ready_pat.push_back(1'b0);
      ready_pat.push_back(1'b1); ready_pat.push_back(1'b0); ready_pat.push_back(1'b1);
    end
    @(posedge clk);
    #1;
    host_start = 1'b0;
    host_empty = 1'b0;
    chk("clear_on_start", 64'({overflow, digest_len, |digest}), 64'(0));
    chk("busy_started", 64'(busy), 64'(1));

    if (!empty) begin
      for (int i = 0; i < msg_q.size(); i++) begin
        if (gaps) begin
          msg_valid = 1'b0;
          msg_last  = 1'b0;
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        msg_data  = msg_q[i];
        msg_valid = 1'b1;
        msg_last  = (i == msg_q.size() - 1);
        g = 0;
        @(negedge clk);
        while (!msg_ready && g < 500) begin @(negedge clk); g++; end
        if (!msg_ready) begin fail_now("feed_timeout"); break; end
        @(posedge clk);
        #1;
      end
      msg_valid = 1'b0;
      msg_last  = 1'b0;
      msg_data  = 8'($urandom);
    end

    if (poke) begin
      g = 0;
      while (fin_cnt == fin0 && g < 2000) begin @(negedge clk); g++; end
      if (fin_cnt == fin0) fail_now("finish_timeout");
      @(posedge clk);
      #1;
      host_start = 1'b1;
      host_empty = 1'b1;
      @(posedge clk);
      #1;
      host_start = 1'b0;
      host_empty = 1'b0;
    end

    g = 0;
    while (exp_dig_q.size() != 0 && g < 4000) begin @(negedge clk); g++; end
    if (exp_dig_q.size() != 0) begin
      fail_now("digest_timeout");
      exp_dig_q.delete(); exp_len_q.delete(); exp_ovf_q.delete();
    end
    g = 0;
    while (busy && g < 50) begin @(negedge clk); g++; end
    if (busy) fail_now("idle_timeout");
    if (empty) chk("empty_no_din", 64'(txn_din_valid), 64'(0));
    else chk("xfer_count", 64'(txn_xfers), 64'(msg_q.size()));
    prev_digest = d;
    have_prev   = 1'b1;
  endtask

  task automatic reset_mid_feed();
    logic [7:0] b[10];
    int idx = 0;
    int g   = 0;
    for (int i = 0; i < 10; i++) begin
      b[i] = 8'($urandom);
      exp_din_q.push_back(b[i]);
    end
    ready_rand = 1'b0;
    @(posedge clk);
    #1;
    host_start    = 1'b1;
    host_empty    = 1'b0;
    exp_start_cyc = cyc + 1;
    exp_starts++;
    @(posedge clk);
    #1;
    host_start = 1'b0;
    msg_valid  = 1'b1;
    msg_last   = 1'b0;
    msg_data   = b[0];
    while (idx < 3 && g < 200) begin
      @(negedge clk);
      g++;
      if (msg_valid && msg_ready) begin
        @(posedge clk);
        #1;
        idx++;
        msg_data = b[idx];
      end
    end
    if (idx < 3) fail_now("reset_feed_timeout");
    #2;
    rst = 1'b1;
    #1;
    chk_zero("reset_mid_feed");
    msg_valid = 1'b0;
    exp_din_q.delete();
    dout_q.delete();
    exp_start_cyc = -1;
    exp_fin_cyc   = -1;
    exp_dv_cyc    = -1;
    repeat (2) @(negedge clk);
    rst         = 1'b0;
    prev_digest = '0;
    have_prev   = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst             = 1'b1;
    host_start      = 1'b0;
    host_empty      = 1'b0;
    msg_data        = 8'h00;
    msg_valid       = 1'b0;
    msg_last        = 1'b0;
    core_din_ready  = 1'b0;
    core_dout       = 8'h00;
    core_dout_valid = 1'b0;
    core_dout_end   = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset_outputs");
    rst = 1'b0;

    // empty message
    ready_rand = 1'b1;
    msg_q.delete();
    run_hash(1'b1, 64, 1'b0, 1'b0, 1'b0, 1'b0);
    // "abc" with ready held high, core emits 0x00..0x3F
    ready_rand = 1'b0;
    set_msg3(8'h61, 8'h62, 8'h63);
    run_hash(1'b0, 64, 1'b1, 1'b0, 1'b0, 1'b0);
    // "123" under a fixed backpressure pattern
    set_msg3(8'h31, 8'h32, 8'h33);
    run_hash(1'b0, 64, 1'b0, 1'b1, 1'b0, 1'b0);
    // overflow by two bytes, then a short digest that must start from clean flags
    ready_rand = 1'b1;
    set_msg_rand(5);
    run_hash(1'b0, 66, 1'b0, 1'b0, 1'b1, 1'b0);
    set_msg_rand(4);
    run_hash(1'b0, 10, 1'b0, 1'b0, 1'b1, 1'b1);
    // length counter saturation
    set_msg_rand(2);
    run_hash(1'b0, 260, 1'b0, 1'b0, 1'b0, 1'b0);
    // abort mid-FEED, then a clean "abc" with a host_start poked during COLLECT
    reset_mid_feed();
    set_msg3(8'h61, 8'h62, 8'h63);
    run_hash(1'b0, 64, 1'b1, 1'b0, 1'b0, 1'b1);
    // random mix
    for (int k = 0; k < 6; k++) begin
      ready_rand = 1'($urandom_range(0, 1));
      set_msg_rand($urandom_range(1, 20));
      run_hash($urandom_range(0, 3) == 0, $urandom_range(60, 70), 1'b0, 1'b0, 1'b1,
               1'($urandom_range(0, 1)));
    end

    chk("start_count", 64'(start_cnt), 64'(exp_starts));
    chk("queues_drained", 64'(exp_din_q.size() + exp_dig_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bloke2b_driver.md
# bloke2b_driver

Synthesizable host-side sequencer for the `bloke2b` hash core. It takes a byte stream from a host, drives the core's start/din/finish handshake, and captures the core's digest byte stream into a parallel register. It sits between a host and `bloke2b`.

## Interface
Parameters:
- `DIGEST_BYTES`, default 64: digest register width in bytes (width is 8*DIGEST_BYTES).
- `CNT_W`, default 8: width of the received-byte counter. Must hold DIGEST_BYTES+1.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `host_start`  in  1: one-cycle request to begin a hash. Ignored unless `busy`=0.
- `host_empty`  in  1: sampled with `host_start`. 1 means a zero-length message.
- `msg_data`  in  8: message byte.
- `msg_valid`  in  1: `msg_data` is valid.
- `msg_last`  in  1: the current byte is the final message byte.
- `msg_ready`  out  1: the byte is accepted on a rising edge where `msg_valid` & `msg_ready`.
- `core_start`, `core_finish`  out  1: to core `start` / `finish`.
- `core_din`  out  8; `core_din_valid`  out  1; `core_din_end`  out  1: to core. `core_din_end` is tied 0.
- `core_din_ready`  in  1: from core.
- `core_dout`  in  8; `core_dout_valid`  in  1; `core_dout_end`  in  1: from core.
- `digest`  out  8*DIGEST_BYTES: captured digest. The first received byte sits in the most-significant position when exactly DIGEST_BYTES bytes are received.
- `digest_len`  out  CNT_W: number of digest bytes received, saturating at 2^CNT_W-1.
- `digest_valid`  out  1: one-cycle pulse when the digest is complete.
- `overflow`  out  1: sticky flag. Set when more than DIGEST_BYTES bytes are received.
- `busy`  out  1: high in every state except IDLE.

## Operation
- The FSM is IDLE → START → WAIT_RDY → FEED → FINISH → COLLECT → DONE → IDLE.
- IDLE:
  - On `host_start`, latch `host_empty`, clear `digest`, `digest_len` and `overflow`, then go to START.
- START:
  - `core_start`=1 for exactly this one cycle. Next state is WAIT_RDY.
- WAIT_RDY:
  - Stay here while `core_din_ready`=0.
  - When `core_din_ready`=1, go to FINISH if the latched empty flag is set, otherwise go to FEED.
- FEED:
  - Pass-through: `core_din`=`msg_data`, `core_din_valid`=`msg_valid`, `msg_ready`=`core_din_ready`. All three are combinational.
  - When a transfer occurs with `msg_last`=1, go to FINISH.
- FINISH:
  - `core_finish`=1 for exactly one cycle, with `core_din_valid`=0. Next state is COLLECT.
- COLLECT, and every other state after START:
  - On each `core_dout_valid`: `digest` <= {`digest`[8*DIGEST_BYTES-9:0], `core_dout`}, and `digest_len` increments.
  - If `digest_len` is already DIGEST_BYTES when a byte arrives, set `overflow`. The shift still occurs and the oldest byte is dropped.
  - `core_dout_end` moves the FSM to DONE. When valid and end occur on the same cycle, the byte is shifted first.
- DONE:
  - `digest_valid`=1 for one cycle. Next state is IDLE.
- Outputs:
  - `core_start`, `core_finish`, `digest_valid` and `busy` are decoded from the state register.
  - `msg_ready`=0 and `core_din_valid`=0 outside FEED.
  - `digest`, `digest_len` and `overflow` hold their values in IDLE until the next accepted `host_start`.

## Timing
- Reset values: state IDLE; all outputs 0 (`digest`=0, `digest_len`=0, `overflow`=0, `busy`=0, `msg_ready`=0, `core_*` outputs 0).
- Reset mid-operation aborts immediately, asynchronously. There is no `core_finish`, and the core is re-synchronised by the next `core_start`.
- `host_start` sampled at edge N:
  - `core_start`=1 during cycle N+1.
  - WAIT_RDY is entered at N+2.
- Earliest first byte transfer: edge N+3, if `core_din_ready` is already high.
- Last-byte transfer at edge M:
  - `core_finish`=1 during M+1.
  - COLLECT begins at M+2.
- `core_dout_end` at edge E: `digest_valid`=1 during E+1, and `busy`=0 from E+2.
- `host_start` while `busy`=1 has no effect.
- The earliest accepted `host_start` is the cycle where `busy`=0 (two cycles after `core_dout_end`).
- FEED stalls indefinitely while `core_din_ready`=0. Data is never dropped or duplicated.

## Test plan
- Empty message: `host_start`+`host_empty`=1 → `core_start` one cycle, no `core_din_valid`, `core_finish` one cycle, the core digest is captured, `digest_len`=64, `digest_valid` pulses once.
- Message "abc" (0x61,0x62,0x63) with `core_din_ready` held high → the core sees exactly the bytes 61,62,63 in order; `core_finish` arrives one cycle after byte 0x63 is accepted.
- Backpressure: "123" with `core_din_ready` toggling 1,0,0,1,0,1 → exactly three transfers, order preserved, `msg_ready` mirrors `core_din_ready` in FEED.
- Digest capture: a core model emits bytes 0x00..0x3F, with `core_dout_end` on the same cycle as 0x3F → `digest`[511:504]=0x00, `digest`[7:0]=0x3F, `overflow`=0.
- Overflow: the core emits 66 bytes → `overflow`=1, `digest_len`=66, `digest` holds the last 64 bytes; the next `host_start` clears `overflow`.
- Reset asserted mid-FEED → all outputs 0 immediately; a fresh "abc" hash afterwards completes correctly; `host_start` pulsed during COLLECT is ignored.
